img_map_engine: RTL and testbench

//  Parametrised successor to the image mapping controller. Loads a full pixel-mapping LUT from scale memory

---
 rtl/img_map_engine_pkg.sv | 17 +
 rtl/img_map_engine_if.sv | 32 +++
 rtl/img_map_lut.sv | 43 ++++
 rtl/img_map_engine.sv | 170 +++++++++++++++++
 tb/tb_img_map_engine.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/img_map_engine_pkg.sv
// Shared types for the image mapping engine: FSM state encoding and a width helper.
package img_map_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } map_state_e;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/img_map_engine_if.sv
// Memory-side bus bundle of the image mapping engine: scale/input read ports and output write port.
interface img_map_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DW     = 128,
    parameter int SC_W   = 128
);
    logic              sc_mem_rd_en;
    logic [ADDR_W-1:0] sc_mem_rd_addr;
    logic [SC_W-1:0]   sc_mem_rd_data;
    logic              inp_mem_rd_en;
    logic [ADDR_W-1:0] inp_mem_rd_addr;
    logic [DW-1:0]     inp_mem_rd_data;
    logic              out_mem_wt_en;
    logic [ADDR_W-1:0] out_mem_wt_addr;
    logic [DW-1:0]     out_mem_wt_data;

    modport master (
        output sc_mem_rd_en, sc_mem_rd_addr,
        input  sc_mem_rd_data,
        output inp_mem_rd_en, inp_mem_rd_addr,
        input  inp_mem_rd_data,
        output out_mem_wt_en, out_mem_wt_addr, out_mem_wt_data
    );

    modport slave (
        input  sc_mem_rd_en, sc_mem_rd_addr,
        output sc_mem_rd_data,
        input  inp_mem_rd_en, inp_mem_rd_addr,
        output inp_mem_rd_data,
        input  out_mem_wt_en, out_mem_wt_addr, out_mem_wt_data
    );
endinterface

// File: rtl/img_map_lut.sv
// Pixel mapping LUT: 2**PIX_W entries, one wide write port (LUT_PER_WORD entries),
// PIX_PER_WORD combinational read ports. Contents clear on reset.
module img_map_lut #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int LUT_PER_WORD = 16,
    parameter int WIDX_W       = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [WIDX_W-1:0]               wr_idx,
    input  logic [PIX_W*LUT_PER_WORD-1:0]   wr_data,
    input  logic [PIX_W*PIX_PER_WORD-1:0]   rd_idx,
    output logic [PIX_W*PIX_PER_WORD-1:0]   rd_data
);
    localparam int LUT_DEPTH = 2**PIX_W;

    logic [PIX_W-1:0] lut_arr [LUT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_entry
            localparam logic [WIDX_W-1:0] WORD = WIDX_W'(gi / LUT_PER_WORD);
            localparam int                LANE = gi % LUT_PER_WORD;
            logic [PIX_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_idx == WORD)) begin
                    entry_reg <= wr_data[LANE*PIX_W +: PIX_W];
                end
            end

            assign lut_arr[gi] = entry_reg;
        end

        for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_rd
            assign rd_data[gi*PIX_W +: PIX_W] = lut_arr[rd_idx[gi*PIX_W +: PIX_W]];
        end
    endgenerate
endmodule

// File: rtl/img_map_engine.sv
// Image mapping engine: loads the LUT from scale memory, then maps every pixel lane of each input word.
// Optional IMG_MAP_BYPASS_EN adds map_bypass, which skips LOAD and copies input words unchanged.
module img_map_engine
    import img_map_engine_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int LUT_PER_WORD = 16,
    parameter int ADDR_W       = 16,
    parameter int OUT_BASE     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
`ifdef IMG_MAP_BYPASS_EN
    input  logic              map_bypass,
`endif
    output logic              busy,
    output logic              output_wt_done,
    img_map_engine_if.master  mem
);
    localparam int DW        = PIX_W * PIX_PER_WORD;
    localparam int LUT_DEPTH = 2**PIX_W;
    localparam int LUT_WORDS = LUT_DEPTH / LUT_PER_WORD;
    localparam int WIDX_W    = idx_w(LUT_WORDS);
    localparam logic [ADDR_W-1:0] LAST_SC = ADDR_W'(LUT_WORDS - 1);
    localparam logic [ADDR_W-1:0] OUT_OFS = ADDR_W'(OUT_BASE);

    map_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] num_words_reg;
    logic              bypass_reg;
    logic [ADDR_W-1:0] sc_addr_reg, sc_cap_addr_reg;
    logic              sc_pending_reg, sc_valid_reg;
    logic [ADDR_W-1:0] inp_addr_reg, inp_cap_idx_reg;
    logic              inp_valid_reg;
    logic              out_wt_en_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [DW-1:0]     out_data_reg;

    logic              abort, run_start, sc_issue, inp_issue, sc_last_cap, inp_last_issue;
    logic              bypass_in, lut_wr_en;
    logic [DW-1:0]     lut_rd_data, mapped_word;

`ifdef IMG_MAP_BYPASS_EN
    assign bypass_in = map_bypass;
`else
    assign bypass_in = 1'b0;
`endif

    always_comb begin
        abort          = !enable && (state_reg inside {ST_LOAD, ST_MAP, ST_DRAIN});
        run_start      = (state_reg == ST_IDLE) && start && enable;
        sc_issue       = (state_reg == ST_LOAD) && sc_pending_reg && !abort;
        inp_issue      = (state_reg == ST_MAP) && !abort;
        sc_last_cap    = sc_valid_reg && (sc_cap_addr_reg == LAST_SC);
        inp_last_issue = inp_issue && (inp_addr_reg == num_words_reg - 1'b1);
        lut_wr_en      = sc_valid_reg && !abort;
        mapped_word    = bypass_reg ? mem.inp_mem_rd_data : lut_rd_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run_start) begin
                    if (!bypass_in)              state_next = ST_LOAD;
                    else if (num_words == '0)    state_next = ST_DONE;
                    else                         state_next = ST_MAP;
                end
            end
            ST_LOAD: begin
                if (abort)            state_next = ST_IDLE;
                else if (sc_last_cap) state_next = (num_words_reg == '0) ? ST_DONE : ST_MAP;
            end
            ST_MAP: begin
                if (abort)               state_next = ST_IDLE;
                else if (inp_last_issue) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Last write is on the bus when nothing is left in the read pipeline.
                if (abort)                                state_next = ST_IDLE;
                else if (out_wt_en_reg && !inp_valid_reg) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_words_reg   <= '0;
            bypass_reg      <= 1'b0;
            sc_addr_reg     <= '0;
            sc_cap_addr_reg <= '0;
            sc_pending_reg  <= 1'b0;
            sc_valid_reg    <= 1'b0;
            inp_addr_reg    <= '0;
            inp_cap_idx_reg <= '0;
            inp_valid_reg   <= 1'b0;
            out_wt_en_reg   <= 1'b0;
            out_addr_reg    <= '0;
            out_data_reg    <= '0;
        end else begin
            sc_valid_reg  <= sc_issue;
            inp_valid_reg <= inp_issue;
            out_wt_en_reg <= inp_valid_reg && !abort;

            if (run_start) begin
                num_words_reg  <= num_words;
                bypass_reg     <= bypass_in;
                sc_addr_reg    <= '0;
                sc_pending_reg <= !bypass_in;
            end

            // Addresses stop on their last value rather than running one past the end.
            if (sc_issue) begin
                sc_cap_addr_reg <= sc_addr_reg;
                if (sc_addr_reg == LAST_SC) sc_pending_reg <= 1'b0;
                else                        sc_addr_reg    <= sc_addr_reg + 1'b1;
            end

            if ((state_next == ST_MAP) && (state_reg != ST_MAP)) inp_addr_reg <= '0;

            if (inp_issue) begin
                inp_cap_idx_reg <= inp_addr_reg;
                if (!inp_last_issue) inp_addr_reg <= inp_addr_reg + 1'b1;
            end

            if (inp_valid_reg) begin
                out_addr_reg <= OUT_OFS + inp_cap_idx_reg;
                out_data_reg <= mapped_word;
            end

            if (abort) sc_pending_reg <= 1'b0;
        end
    end

    img_map_lut #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD),
        .LUT_PER_WORD (LUT_PER_WORD),
        .WIDX_W       (WIDX_W)
    ) u_lut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (lut_wr_en),
        .wr_idx  (sc_cap_addr_reg[WIDX_W-1:0]),
        .wr_data (mem.sc_mem_rd_data),
        .rd_idx  (mem.inp_mem_rd_data),
        .rd_data (lut_rd_data)
    );

    // Abort gates the strobes in the very cycle enable drops, so nothing leaks out.
    assign mem.sc_mem_rd_en    = sc_issue;
    assign mem.sc_mem_rd_addr  = sc_addr_reg;
    assign mem.inp_mem_rd_en   = inp_issue;
    assign mem.inp_mem_rd_addr = inp_addr_reg;
    assign mem.out_mem_wt_en   = out_wt_en_reg && !abort;
    assign mem.out_mem_wt_addr = out_addr_reg;
    assign mem.out_mem_wt_data = out_data_reg;
    assign busy                = state_reg inside {ST_LOAD, ST_MAP, ST_DRAIN};
    assign output_wt_done      = (state_reg == ST_DONE);
endmodule

// File: tb/tb_img_map_engine.sv
// Self-checking bench for img_map_engine: memory models, event monitor and a LUT-level reference model.
module tb_img_map_engine;
    localparam int PIX_W     = 8;
    localparam int PPW       = 16;
    localparam int LPW       = 16;
    localparam int ADDR_W    = 16;
    localparam int OUT_BASE  = 0;
    localparam int DW        = PIX_W * PPW;
    localparam int SC_W      = PIX_W * LPW;
    localparam int LUT_WORDS = 256 / LPW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_words = '0;
    logic              busy, output_wt_done;
`ifdef IMG_MAP_BYPASS_EN
    logic              map_bypass = 1'b0;
`endif

    img_map_engine_if #(.ADDR_W(ADDR_W), .DW(DW), .SC_W(SC_W)) mem_if ();

    img_map_engine #(
        .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .LUT_PER_WORD(LPW), .ADDR_W(ADDR_W), .OUT_BASE(OUT_BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .num_words      (num_words),
`ifdef IMG_MAP_BYPASS_EN
        .map_bypass     (map_bypass),
`endif
        .busy           (busy),
        .output_wt_done (output_wt_done),
        .mem            (mem_if)
    );

    always #5 clk = ~clk;

    // Memory models: registered read, data valid the cycle after the strobe.
    logic [SC_W-1:0] sc_mem  [LUT_WORDS];
    logic [DW-1:0]   inp_mem [64];
    int              lut_model [256];

    always @(posedge clk) begin
        if (mem_if.sc_mem_rd_en)  mem_if.sc_mem_rd_data  <= sc_mem[mem_if.sc_mem_rd_addr[3:0]];
        if (mem_if.inp_mem_rd_en) mem_if.inp_mem_rd_data <= inp_mem[mem_if.inp_mem_rd_addr[5:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit            mon_on = 1'b0;
    int            sc_cyc_q[$], sc_addr_q[$], inp_cyc_q[$], inp_addr_q[$];
    int            wr_cyc_q[$], wr_addr_q[$], done_cyc_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            busy_cnt = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (mem_if.sc_mem_rd_en) begin
                sc_cyc_q.push_back(cyc);
                sc_addr_q.push_back(int'(mem_if.sc_mem_rd_addr));
            end
            if (mem_if.inp_mem_rd_en) begin
                inp_cyc_q.push_back(cyc);
                inp_addr_q.push_back(int'(mem_if.inp_mem_rd_addr));
            end
            if (mem_if.out_mem_wt_en) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(int'(mem_if.out_mem_wt_addr));
                wr_data_q.push_back(mem_if.out_mem_wt_data);
            end
            if (output_wt_done) done_cyc_q.push_back(cyc);
            if (busy) busy_cnt++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_map(input logic [DW-1:0] w, input bit byp);
        logic [DW-1:0] r;
        r = '0;
        if (byp) return w;
        for (int i = 0; i < PPW; i++) r[i*PIX_W +: PIX_W] = 8'(lut_model[w[i*PIX_W +: PIX_W]]);
        return r;
    endfunction

    // kind 0: identity, 1: inverted, otherwise random
    task automatic set_lut(input int kind);
        for (int n = 0; n < 256; n++)
            lut_model[n] = (kind == 0) ? n : (kind == 1) ? 255 - n : int'($urandom_range(0, 255));
        for (int k = 0; k < LUT_WORDS; k++)
            for (int i = 0; i < LPW; i++)
                sc_mem[k][i*PIX_W +: PIX_W] = 8'(lut_model[k*LPW + i]);
    endtask

    task automatic run_job(input string tag, input int n, input bit byp, input int abort_at,
                           input bit restart_mid);
        int s, m0, t, exp_inp, exp_wr, exp_done_cyc;
        @(posedge clk); #1;
        sc_cyc_q.delete(); sc_addr_q.delete(); inp_cyc_q.delete(); inp_addr_q.delete();
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); done_cyc_q.delete();
        busy_cnt = 0;
        mon_on = 1'b1;
        num_words = ADDR_W'(n);
`ifdef IMG_MAP_BYPASS_EN
        map_bypass = byp;
`endif
        enable = 1'b1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        m0 = byp ? s + 1 : s + LUT_WORDS + 2;
        if (abort_at >= 0) begin
            t = 0;
            while (cyc < m0 + abort_at && t < 200) begin @(posedge clk); #1; t++; end
            enable = 1'b0;
            @(posedge clk); #1;
            enable = 1'b1;
            repeat (8) begin @(posedge clk); #1; end
        end else begin
            t = 0;
            while (done_cyc_q.size() == 0 && t < 400) begin
                @(posedge clk); #1; t++;
                start = (restart_mid && cyc == m0 + 1) ? 1'b1 : 1'b0;
            end
            start = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
        end
        mon_on = 1'b0;

        exp_inp = (abort_at >= 0) ? abort_at : n;
        exp_wr  = (abort_at >= 0) ? 0 : n;
        check({tag, "_sc_cnt"}, sc_cyc_q.size(), byp ? 0 : LUT_WORDS);
        for (int k = 0; k < sc_cyc_q.size() && k < LUT_WORDS; k++) begin
            check({tag, "_sc_addr"}, sc_addr_q[k], k);
            check({tag, "_sc_cyc"}, sc_cyc_q[k], s + 1 + k);
        end
        check({tag, "_inp_cnt"}, inp_cyc_q.size(), exp_inp);
        for (int j = 0; j < inp_cyc_q.size() && j < exp_inp; j++) begin
            check({tag, "_inp_addr"}, inp_addr_q[j], j);
            check({tag, "_inp_cyc"}, inp_cyc_q[j], m0 + j);
        end
        check({tag, "_wr_cnt"}, wr_cyc_q.size(), exp_wr);
        for (int j = 0; j < wr_cyc_q.size() && j < exp_wr; j++) begin
            check({tag, "_wr_addr"}, wr_addr_q[j], (OUT_BASE + j) % 65536);
            check({tag, "_wr_data"}, wr_data_q[j], ref_map(inp_mem[j], byp));
            check({tag, "_wr_cyc"}, wr_cyc_q[j], m0 + 2 + j);
        end
        check({tag, "_done_cnt"}, done_cyc_q.size(), (abort_at >= 0) ? 0 : 1);
        if (abort_at >= 0) begin
            check({tag, "_busy_cyc"}, busy_cnt, m0 + abort_at - s);
        end else begin
            exp_done_cyc = (n == 0) ? (byp ? s + 1 : s + LUT_WORDS + 2) : m0 + n + 2;
            if (done_cyc_q.size() > 0) check({tag, "_done_cyc"}, done_cyc_q[0], exp_done_cyc);
            check({tag, "_busy_cyc"}, busy_cnt, exp_done_cyc - s - 1);
        end
        check({tag, "_idle_flags"}, {busy, output_wt_done}, 2'b00);
        $display("job %s n=%0d bypass=%0d: sc=%0d inp=%0d wr=%0d done=%0d", tag, n, byp,
                 sc_cyc_q.size(), inp_cyc_q.size(), wr_cyc_q.size(), done_cyc_q.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w, e;
        int n;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {mem_if.sc_mem_rd_en, mem_if.inp_mem_rd_en, mem_if.out_mem_wt_en,
                           busy, output_wt_done}, 0);
        check("rst_addr", {mem_if.sc_mem_rd_addr, mem_if.inp_mem_rd_addr, mem_if.out_mem_wt_addr}, 0);
        check("rst_data", mem_if.out_mem_wt_data, 0);
        reset = 1'b1;

        // identity LUT, lanes 0x0F1F..EFFF
        set_lut(0);
        for (int i = 0; i < PPW; i++) w[i*PIX_W +: PIX_W] = 8'(255 - 16*i);
        for (int j = 0; j < 4; j++) inp_mem[j] = w;
        run_job("ident", 4, 1'b0, -1, 1'b0);
        if (wr_data_q.size() > 0) check("ident_passthru", wr_data_q[0], w);

        // inverted LUT, ascending lanes 0x00..0F -> 0xFF..F0
        set_lut(1);
        for (int i = 0; i < PPW; i++) begin
            w[i*PIX_W +: PIX_W] = 8'(i);
            e[i*PIX_W +: PIX_W] = 8'(255 - i);
        end
        inp_mem[0] = w;
        inp_mem[1] = w;
        run_job("invert", 2, 1'b0, -1, 1'b0);
        if (wr_data_q.size() > 0) check("invert_word0", wr_data_q[0], e);

        run_job("zero_len", 0, 1'b0, -1, 1'b0);

        set_lut(2);
        for (int j = 0; j < 64; j++) inp_mem[j] = {$urandom, $urandom, $urandom, $urandom};
        run_job("abort", 6, 1'b0, 2, 1'b0);
        run_job("after_abort", 3, 1'b0, -1, 1'b0);
        run_job("restart_ign", 5, 1'b0, -1, 1'b1);

        // reset in the middle of LOAD
        @(posedge clk); #1;
        num_words = 16'd4;
        enable = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midload_sc_en", mem_if.sc_mem_rd_en, 1'b1);
        reset = 1'b0;
        #1;
        check("midload_rst_ctrl", {mem_if.sc_mem_rd_en, mem_if.inp_mem_rd_en, mem_if.out_mem_wt_en,
                                   busy, output_wt_done}, 0);
        check("midload_rst_addr", {mem_if.sc_mem_rd_addr, mem_if.inp_mem_rd_addr,
                                   mem_if.out_mem_wt_addr}, 0);
        check("midload_rst_data", mem_if.out_mem_wt_data, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        run_job("after_reset", 2, 1'b0, -1, 1'b0);

`ifdef IMG_MAP_BYPASS_EN
        run_job("bypass", 5, 1'b1, -1, 1'b0);
        run_job("bypass_map", 3, 1'b0, -1, 1'b0);
`endif

        for (int r = 0; r < 6; r++) begin
            set_lut(2);
            n = int'($urandom_range(1, 24));
            for (int j = 0; j < n; j++) inp_mem[j] = {$urandom, $urandom, $urandom, $urandom};
            run_job("random", n, 1'b0, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
